fb_scanout_ctl: RTL and testbench

Frame-scanout sequencer for the HDMI framebuffer path, in the AXI clock domain. It is driven by the AXI register decoder and a synchronized vblank level. It sequences, once per frame, the async pixel FIFO flush and the DMA reader start. It provides vsync-aligned page flipping of the framebuffer base address and counts completed and short (truncated) frames for software.

---
 rtl/fb_scanout_ctl.sv | 208 ++++++++++++++++++++
 tb/tb_fb_scanout_ctl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scanout_ctl.sv
// fb_scanout_ctl: per-frame scanout sequencer for the HDMI framebuffer path (AXI clock domain).
// Once per vblank edge it pulses the pixel FIFO reset, issues a DMA start, counts the returned
// beats, and applies any pending framebuffer page flip. It also keeps frame and short counters.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   i_wr/i_wreg/i_wdata register write strobe, index, data
//   i_rreg/o_rdata      register read index, combinational read data
//   i_vsync             synchronized vblank level
//   i_valid             DMA reader beat valid
//   o_start             one-cycle DMA start pulse
//   o_baseaddr          DMA base address (current base)
//   o_burst_count       DMA burst count latched at frame start
//   o_fifo_reset        pixel FIFO reset (FLUSH state)
//   o_busy              high in FLUSH, START, RUN
//   o_irq               one-cycle pulse when a pending flip is applied
module fb_scanout_ctl #(
  parameter logic [31:0] ADDR_RESET      = 32'h1000_0000,
  parameter logic [31:0] BURSTS_RESET    = 32'd36000,
  parameter int unsigned BEATS_PER_BURST = 16,
  parameter int unsigned FLUSH_CYCLES    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wr,
  input  logic [1:0]  i_wreg,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_rreg,
  output logic [31:0] o_rdata,
  input  logic        i_vsync,
  input  logic        i_valid,
  output logic        o_start,
  output logic [31:0] o_baseaddr,
  output logic [31:0] o_burst_count,
  output logic        o_fifo_reset,
  output logic        o_busy,
  output logic        o_irq
);

  localparam int unsigned   FCW        = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_CYCLES - 1);
  localparam logic [31:0]   BEATS      = 32'(BEATS_PER_BURST);

  typedef enum logic [2:0] {StIdle, StFlush, StStart, StRun, StDone} state_e;

  state_e          r_state, w_state_d;
  logic            r_vsync;
  logic            r_enable, w_enable_d;
  logic            r_pending, w_pending_d;
  logic [31:0]     r_cur_base, w_cur_base_d;
  logic [31:0]     r_pend_base, w_pend_base_d;
  logic [31:0]     r_burst_reg, w_burst_reg_d;
  logic [31:0]     r_burst_lat, w_burst_lat_d;
  logic [31:0]     r_beat_cnt, w_beat_cnt_d;
  logic [FCW-1:0]  r_flush_cnt, w_flush_cnt_d;
  logic [15:0]     r_frame_cnt, w_frame_cnt_d;
  logic [15:0]     r_short_cnt, w_short_cnt_d;
  logic            r_irq, w_irq_d;

  logic        w_edge;
  logic        w_busy;
  logic        w_last_beat;
  logic [31:0] w_target;
  logic [31:0] w_beat_inc;
  logic [15:0] w_frame_inc;
  logic [15:0] w_short_inc;

  assign w_edge      = i_vsync & ~r_vsync;
  assign w_busy      = (r_state == StFlush) || (r_state == StStart) || (r_state == StRun);
  assign w_target    = r_burst_lat * BEATS;
  assign w_beat_inc  = r_beat_cnt + 32'd1;
  assign w_last_beat = i_valid && (w_beat_inc == w_target);
  assign w_frame_inc = r_frame_cnt + 16'd1;
  assign w_short_inc = (r_short_cnt == 16'hFFFF) ? r_short_cnt : r_short_cnt + 16'd1;

  always_comb begin
    w_state_d     = r_state;
    w_enable_d    = r_enable;
    w_pending_d   = r_pending;
    w_cur_base_d  = r_cur_base;
    w_pend_base_d = r_pend_base;
    w_burst_reg_d = r_burst_reg;
    w_burst_lat_d = r_burst_lat;
    w_beat_cnt_d  = r_beat_cnt;
    w_flush_cnt_d = r_flush_cnt;
    w_frame_cnt_d = r_frame_cnt;
    w_short_cnt_d = r_short_cnt;
    w_irq_d       = 1'b0;

    unique case (r_state)
      StIdle, StDone: begin
        if (w_edge) begin
          if (r_enable) begin
            w_state_d     = StFlush;
            w_burst_lat_d = r_burst_reg;
            w_beat_cnt_d  = '0;
            w_flush_cnt_d = '0;
            if (r_pending) begin
              w_cur_base_d = r_pend_base;
              w_pending_d  = 1'b0;
              w_irq_d      = 1'b1;
            end
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      StFlush: begin
        if (r_flush_cnt == FLUSH_LAST) begin
          // An empty frame never starts the DMA but still counts as completed.
          if (r_burst_lat == 32'd0) begin
            w_state_d     = StDone;
            w_frame_cnt_d = w_frame_inc;
          end else begin
            w_state_d = StStart;
          end
        end else begin
          w_flush_cnt_d = r_flush_cnt + FCW'(1);
        end
      end
      StStart: w_state_d = StRun;
      StRun: begin
        if (i_valid) begin
          w_beat_cnt_d = w_beat_inc;
        end
        if (w_last_beat) begin
          w_state_d     = StDone;
          w_frame_cnt_d = w_frame_inc;
        end else if (w_edge) begin
          // The reader cannot be aborted: record the overrun and keep draining.
          w_short_cnt_d = w_short_inc;
        end
      end
      default: w_state_d = StIdle;
    endcase

    // Writes are applied last so a clear beats a same-cycle increment and a base
    // write arriving with the edge stays pending for the following frame.
    if (i_wr) begin
      unique case (i_wreg)
        2'd0: begin
          w_enable_d = i_wdata[0];
          if (i_wdata[1]) begin
            w_frame_cnt_d = '0;
            w_short_cnt_d = '0;
          end
        end
        2'd1: begin
          w_pend_base_d = i_wdata;
          w_pending_d   = 1'b1;
        end
        2'd2: w_burst_reg_d = i_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_vsync     <= 1'b0;
      r_enable    <= 1'b0;
      r_pending   <= 1'b0;
      r_cur_base  <= ADDR_RESET;
      r_pend_base <= ADDR_RESET;
      r_burst_reg <= BURSTS_RESET;
      r_burst_lat <= BURSTS_RESET;
      r_beat_cnt  <= '0;
      r_flush_cnt <= '0;
      r_frame_cnt <= '0;
      r_short_cnt <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_vsync     <= i_vsync;
      r_enable    <= w_enable_d;
      r_pending   <= w_pending_d;
      r_cur_base  <= w_cur_base_d;
      r_pend_base <= w_pend_base_d;
      r_burst_reg <= w_burst_reg_d;
      r_burst_lat <= w_burst_lat_d;
      r_beat_cnt  <= w_beat_cnt_d;
      r_flush_cnt <= w_flush_cnt_d;
      r_frame_cnt <= w_frame_cnt_d;
      r_short_cnt <= w_short_cnt_d;
      r_irq       <= w_irq_d;
    end
  end

  assign o_start       = (r_state == StStart);
  assign o_fifo_reset  = (r_state == StFlush);
  assign o_busy        = w_busy;
  assign o_irq         = r_irq;
  assign o_baseaddr    = r_cur_base;
  assign o_burst_count = r_burst_lat;

  always_comb begin
    o_rdata = '0;
    unique case (i_rreg)
      2'd0: o_rdata = {r_frame_cnt, 13'd0, r_pending, w_busy, r_enable};
      2'd1: o_rdata = r_cur_base;
      2'd2: o_rdata = r_pend_base;
      2'd3: o_rdata = {16'd0, r_short_cnt};
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fb_scanout_ctl.sv
module tb_fb_scanout_ctl;
  localparam logic [31:0] ADDR_RST = 32'h1000_0000;
  localparam logic [31:0] BURST_RST = 32'd2;
  localparam int BPB = 16;
  localparam int FLC = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_wr = 1'b0;
  logic [1:0]  i_wreg = '0;
  logic [31:0] i_wdata = '0;
  logic [1:0]  i_rreg = '0;
  logic [31:0] o_rdata;
  logic        i_vsync = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_start, o_fifo_reset, o_busy, o_irq;
  logic [31:0] o_baseaddr, o_burst_count;

  int n_chk = 0;
  int n_err = 0;

  // Software-visible model, updated per transaction rather than per cycle.
  bit          m_enable, m_pending;
  logic [31:0] m_cur, m_pend_base, m_burst_reg, m_burst_lat;
  logic [15:0] m_frame, m_short;

  fb_scanout_ctl #(
    .ADDR_RESET(ADDR_RST), .BURSTS_RESET(BURST_RST),
    .BEATS_PER_BURST(BPB), .FLUSH_CYCLES(FLC)
  ) dut (
    .clk(clk), .reset(reset), .i_wr(i_wr), .i_wreg(i_wreg), .i_wdata(i_wdata),
    .i_rreg(i_rreg), .o_rdata(o_rdata), .i_vsync(i_vsync), .i_valid(i_valid),
    .o_start(o_start), .o_baseaddr(o_baseaddr), .o_burst_count(o_burst_count),
    .o_fifo_reset(o_fifo_reset), .o_busy(o_busy), .o_irq(o_irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] d);
    i_wr = 1'b1; i_wreg = r; i_wdata = d;
    tick();
    i_wr = 1'b0;
  endtask

  task automatic rd(input logic [1:0] r, output logic [31:0] d);
    i_rreg = r;
    #1;
    d = o_rdata;
  endtask

  function automatic logic [31:0] exp0(input bit busy);
    return {m_frame, 13'd0, m_pending, busy, m_enable};
  endfunction

  task automatic model_reset();
    m_enable = 0; m_pending = 0; m_cur = ADDR_RST; m_pend_base = ADDR_RST;
    m_burst_reg = BURST_RST; m_burst_lat = BURST_RST; m_frame = 0; m_short = 0;
  endtask

  // One vsync-driven frame. Optional events: short edge before beat short_at, base write
  // before beat wbase_at, disable before beat dis_at, counter clear on the final beat,
  // base write in the same cycle as the starting edge.
  task automatic do_frame(input int short_at, input int wbase_at, input logic [31:0] wbase,
                          input int dis_at, input bit clr_last, input bit base_on_edge,
                          input logic [31:0] edge_base);
    bit flip;
    int target;
    logic [31:0] d;
    logic [3:0] ctl;
    i_vsync = 1'b1;
    if (base_on_edge) begin i_wr = 1'b1; i_wreg = 2'd1; i_wdata = edge_base; end
    tick();
    i_vsync = 1'b0; i_wr = 1'b0;
    if (!m_enable) begin
      if (base_on_edge) begin m_pend_base = edge_base; m_pending = 1; end
      for (int i = 0; i < FLC + 3; i++) begin
        ctl = {o_fifo_reset, o_start, o_busy, o_irq};
        n_chk++;
        if (ctl !== 4'b0000) begin
          n_err++; $display("FAIL disabled_edge c%0d: got %b want 0000", i, ctl);
        end
        tick();
      end
      rd(2'd0, d);
      n_chk++;
      if (d !== exp0(0)) begin n_err++; $display("FAIL disabled_reg0: got %h want %h", d, exp0(0)); end
      return;
    end
    flip = m_pending;
    if (flip) begin m_cur = m_pend_base; m_pending = 0; end
    m_burst_lat = m_burst_reg;
    if (base_on_edge) begin m_pend_base = edge_base; m_pending = 1; end
    for (int i = 0; i < FLC; i++) begin
      ctl = {o_fifo_reset, o_start, o_busy, o_irq};
      n_chk++;
      if (ctl !== {3'b101, (i == 0) && flip}) begin
        n_err++; $display("FAIL flush c%0d: got %b want %b", i, ctl, {3'b101, (i == 0) && flip});
      end
      n_chk++;
      if ({o_baseaddr, o_burst_count} !== {m_cur, m_burst_lat}) begin
        n_err++; $display("FAIL flush_addr c%0d: got %h/%0d want %h/%0d", i, o_baseaddr,
                          o_burst_count, m_cur, m_burst_lat);
      end
      tick();
    end
    if (m_burst_lat == 0) begin
      m_frame++;
      ctl = {o_fifo_reset, o_start, o_busy, o_irq};
      n_chk++;
      if (ctl !== 4'b0000) begin n_err++; $display("FAIL empty_done: got %b want 0000", ctl); end
      rd(2'd0, d);
      n_chk++;
      if (d !== exp0(0)) begin n_err++; $display("FAIL empty_reg0: got %h want %h", d, exp0(0)); end
      return;
    end
    ctl = {o_fifo_reset, o_start, o_busy, o_irq};
    n_chk++;
    if (ctl !== 4'b0110) begin n_err++; $display("FAIL start: got %b want 0110", ctl); end
    tick();
    target = int'(m_burst_lat) * BPB;
    for (int b = 0; b < target; b++) begin
      if (b == short_at) begin
        i_vsync = 1'b1; tick(); i_vsync = 1'b0;
        if (m_short != 16'hFFFF) m_short++;
      end
      if (b == wbase_at) begin
        wr(2'd1, wbase);
        m_pend_base = wbase; m_pending = 1;
        rd(2'd0, d);
        n_chk++;
        if (d !== exp0(1) || o_baseaddr !== m_cur) begin
          n_err++; $display("FAIL midrun_write: got %h/%h want %h/%h", d, o_baseaddr, exp0(1), m_cur);
        end
      end
      if (b == dis_at) begin
        wr(2'd0, 32'd0);
        m_enable = 0;
      end
      repeat ($urandom_range(0, 2)) begin
        ctl = {o_fifo_reset, o_start, o_busy, o_irq};
        n_chk++;
        if (ctl !== 4'b0010) begin n_err++; $display("FAIL run b%0d: got %b want 0010", b, ctl); end
        tick();
      end
      i_valid = 1'b1;
      if (clr_last && b == target - 1) begin
        i_wr = 1'b1; i_wreg = 2'd0; i_wdata = {30'd0, 1'b1, m_enable};
      end
      tick();
      i_valid = 1'b0; i_wr = 1'b0;
    end
    m_frame++;
    if (clr_last) begin m_frame = 0; m_short = 0; end
    ctl = {o_fifo_reset, o_start, o_busy, o_irq};
    n_chk++;
    if (ctl !== 4'b0000) begin n_err++; $display("FAIL done: got %b want 0000", ctl); end
    rd(2'd0, d);
    n_chk++;
    if (d !== exp0(0)) begin n_err++; $display("FAIL done_reg0: got %h want %h", d, exp0(0)); end
    rd(2'd3, d);
    n_chk++;
    if (d !== {16'd0, m_short}) begin n_err++; $display("FAIL done_short: got %h want %h", d, m_short); end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    model_reset();
    tick(); tick();
    reset = 1'b0;
    tick();
    n_chk++;
    if ({o_fifo_reset, o_start, o_busy, o_irq, o_baseaddr, o_burst_count} !==
        {4'b0000, ADDR_RST, BURST_RST}) begin
      n_err++; $display("FAIL reset_outs: got %b %h %0d", {o_fifo_reset, o_start, o_busy, o_irq},
                        o_baseaddr, o_burst_count);
    end
    for (int r = 0; r < 4; r++) begin
      logic [31:0] e;
      e = (r == 1 || r == 2) ? ADDR_RST : 32'd0;
      rd(2'(r), d);
      n_chk++;
      if (d !== e) begin n_err++; $display("FAIL reset_reg%0d: got %h want %h", r, d, e); end
    end
  endtask

  task automatic test_basic_frame();
    wr(2'd0, 32'd1); m_enable = 1;
    tick(); tick();
    do_frame(-1, -1, 0, -1, 0, 0, 0);
  endtask

  task automatic test_page_flip();
    logic [31:0] d;
    do_frame(-1, 10, 32'h1800_0000, -1, 0, 0, 0);
    do_frame(-1, -1, 0, -1, 0, 0, 0);
    rd(2'd1, d);
    n_chk++;
    if (d !== 32'h1800_0000) begin n_err++; $display("FAIL flip_base: got %h want 18000000", d); end
  endtask

  task automatic test_short_frame();
    do_frame(20, -1, 0, -1, 0, 0, 0);
    do_frame(-1, -1, 0, -1, 0, 0, 0);
  endtask

  task automatic test_zero_bursts();
    wr(2'd2, 32'd0); m_burst_reg = 0;
    do_frame(-1, -1, 0, -1, 0, 0, 0);
    wr(2'd2, 32'd2); m_burst_reg = 2;
    do_frame(-1, -1, 0, -1, 0, 0, 0);
  endtask

  task automatic test_base_on_edge();
    do_frame(-1, -1, 0, -1, 0, 1, $urandom & 32'hFFFF_FFF0);
    do_frame(-1, -1, 0, -1, 0, 0, 0);
  endtask

  task automatic test_disable();
    do_frame(-1, -1, 0, 5, 0, 0, 0);
    do_frame(-1, -1, 0, -1, 0, 0, 0);
    wr(2'd0, 32'd1); m_enable = 1;
    do_frame(-1, -1, 0, -1, 0, 0, 0);
  endtask

  task automatic test_clear_collision();
    do_frame(7, -1, 0, -1, 1, 0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      logic [31:0] nb;
      nb = $urandom_range(1, 3);
      wr(2'd2, nb); m_burst_reg = nb;
      do_frame(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : -1,
               ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15)) : -1,
               $urandom & 32'hFFFF_FFF0, -1, 0, 0, 0);
    end
  endtask

  task automatic test_reset_mid_flush();
    logic [31:0] d;
    wr(2'd1, 32'h2000_0000); m_pend_base = 32'h2000_0000; m_pending = 1;
    i_vsync = 1'b1; tick(); i_vsync = 1'b0; tick();
    reset = 1'b1;
    #1;
    model_reset();
    n_chk++;
    if ({o_fifo_reset, o_start, o_busy, o_irq, o_baseaddr, o_burst_count} !==
        {4'b0000, ADDR_RST, BURST_RST}) begin
      n_err++; $display("FAIL midflush_reset: got %b %h %0d", {o_fifo_reset, o_start, o_busy, o_irq},
                        o_baseaddr, o_burst_count);
    end
    rd(2'd0, d);
    n_chk++;
    if (d !== 32'd0) begin n_err++; $display("FAIL midflush_reg0: got %h want 0", d); end
    tick();
    reset = 1'b0;
    tick();
    wr(2'd0, 32'd1); m_enable = 1;
    do_frame(-1, -1, 0, -1, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_page_flip();
    test_short_frame();
    test_zero_bursts();
    test_base_on_edge();
    test_disable();
    test_clear_collision();
    test_random();
    test_reset_mid_flush();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
